pe_operand_splitter: RTL
========================

# pe_operand_splitter

Sequential operand slicer for the vector-core PE array. It is the issue-side counterpart of the shift-recombining adder. A 16-bit signed operand is decomposed into two 9-bit signed slices, high slice first, and streamed to an 8x8-class multiplier lane. Tags on each beat tell the downstream recombiner whether to apply the 8-bit shift and when an operand is complete. Narrow (8-bit) operands pass through as a single beat.

## Interface
- DATA_WIDTH, 16, input operand width; must equal 2*SLICE_WIDTH
- SLICE_WIDTH, 8, slice payload width; output slice is SLICE_WIDTH+1 bits
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand offered
- in_ready  out  1  operand accepted when in_valid && in_ready
- in_data  in  DATA_WIDTH  signed operand
- in_wide  in  1  1: split into two beats; 0: narrow, uses in_data[SLICE_WIDTH-1:0] as signed
- out_valid  out  1  slice beat valid
- out_ready  in  1  downstream accepts beat when out_valid && out_ready
- out_slice  out  SLICE_WIDTH+1  signed slice
- out_is_high  out  1  beat is the high slice; drives the recombiner's shift select
- out_last  out  1  final beat of the operand

## Operation
- FSM states: IDLE (output empty), HIGH (high beat presented), LOW (low beat presented, low half held in internal register), NARROW (single beat presented).
- Slice formation, wide: high = sign-extend(in_data[15:8]) to 9 bits; low = {1'b0, in_data[7:0]}. This zero-extends the low half. Invariant: high*256 + low == in_data.
- Slice formation, narrow: slice = sign-extend(in_data[7:0]); in_data[15:8] is ignored.
- Beat tags: high beat is_high=1, last=0; low beat is_high=0, last=1; narrow beat is_high=0, last=1.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). A new operand may therefore be accepted in the same cycle the last beat drains.
- Transitions:
  - IDLE, accept: go to HIGH if wide, else NARROW.
  - HIGH, beat accepted: go to LOW.
  - LOW or NARROW, beat accepted: if a new operand is accepted in the same cycle, go to HIGH or NARROW according to its in_wide; otherwise go to IDLE.
  - Any state with no handshake: hold.
- While out_valid && !out_ready, out_slice, out_is_high and out_last are held stable. The low-half register is not overwritten.
- There are no other sources of state change.

## Timing
- Reset values: state=IDLE, out_valid=0, out_slice=0, out_is_high=0, out_last=0, low-half register=0. in_ready=1 after reset.
- Reset asserted mid-operand discards any pending beat immediately (asynchronous). No partial operand is emitted after release.
- Latency: input accept at cycle N gives the first beat with out_valid=1 at cycle N+1.
- Throughput with out_ready held high:
  - narrow: one operand per cycle;
  - wide: one operand per 2 cycles, with no bubble between operands.
- Outputs are fully registered. in_ready is the only combinational output; its path is from out_ready.
- in_wide and in_data are sampled only on an input handshake.

## Structure
- Shared vector-core package: SLICE_WIDTH default, and the FSM state encoding (2-bit localparams IDLE/HIGH/LOW/NARROW).
- Natural sub-module: pe_slice_extend, combinational. Inputs: operand and wide flag. Outputs: 9-bit high slice and 9-bit low slice, with the sign/zero-extension rules above. This module is reused by any other slicer lane.
- The top holds the FSM, the output registers and the low-half register.

## Test plan
- Wide split: in_data=16'h8001, in_wide=1, out_ready=1. Required: beat1 slice=9'h180, is_high=1, last=0; beat2 slice=9'h001, is_high=0, last=1. Recombined value (-128*256+1) = 0x8001.
- Narrow: in_data=16'h12FF, in_wide=0. Required: one beat, slice=9'h1FF (-1), is_high=0, last=1, appearing one cycle after accept.
- Back-to-back: 4 narrow operands then 3 wide operands with out_ready=1. Required: 10 beats in 10 consecutive cycles with no bubble, and in_ready low only during HIGH states.
- Backpressure: wide 16'h7F80, out_ready=0 for 5 cycles in HIGH and again in LOW. Required: slice 9'h07F and then 9'h080 held stable, in_ready=0 throughout, no beat lost or duplicated.
- Reset mid-operand: assert rst while in LOW with slice 9'h0AB pending. Required: out_valid=0 immediately, all outputs at reset values. After release, the next operand 16'h0102 emits 9'h001 then 9'h002 only.
- Random regression: 10k operands with random out_ready. Required: the recombined stream equals the input stream exactly.

Source files
------------

// File: rtl/pe_operand_splitter_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// pe_operand_splitter_pkg : shared vector-core slice widths and FSM encoding
// Revision: 1.0
// ------------------------------------------------------------------------
package pe_operand_splitter_pkg;

   localparam int SLICE_WIDTH_DEF = 8;
   localparam int DATA_WIDTH_DEF  = 2 * SLICE_WIDTH_DEF;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HIGH   = 2'd1;
   localparam logic [1:0] ST_LOW    = 2'd2;
   localparam logic [1:0] ST_NARROW = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      HIGH   = ST_HIGH,
      LOW    = ST_LOW,
      NARROW = ST_NARROW
   } splitter_state_e;

endpackage : pe_operand_splitter_pkg
`default_nettype wire

// File: rtl/pe_slice_extend.sv
`default_nettype none
// ------------------------------------------------------------------------
// pe_slice_extend : splits an operand into signed high / low multiplier slices
// Revision: 1.0
// ------------------------------------------------------------------------
module pe_slice_extend
   import pe_operand_splitter_pkg::*;
#(
   parameter int SLICE_WIDTH = SLICE_WIDTH_DEF,
   parameter int DATA_WIDTH  = 2 * SLICE_WIDTH
) (
   input  logic [DATA_WIDTH-1:0]  operand_i,
   input  logic                   wide_i,
   output logic [SLICE_WIDTH:0]   high_o,
   output logic [SLICE_WIDTH:0]   low_o
);

   assign high_o = {operand_i[DATA_WIDTH-1], operand_i[DATA_WIDTH-1 -: SLICE_WIDTH]};

   // Wide low halves are unsigned so that high*2^SLICE_WIDTH + low == operand;
   // narrow operands are the low half taken as signed.
   assign low_o  = {(wide_i ? 1'b0 : operand_i[SLICE_WIDTH-1]), operand_i[SLICE_WIDTH-1:0]};

endmodule : pe_slice_extend
`default_nettype wire

// File: rtl/pe_operand_splitter.sv
`default_nettype none
// ------------------------------------------------------------------------
// pe_operand_splitter : streams wide operands as high/low slice beats
// Revision: 1.0
// ------------------------------------------------------------------------
module pe_operand_splitter
   import pe_operand_splitter_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int SLICE_WIDTH = SLICE_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_WIDTH-1:0]  in_data,
   input  logic                   in_wide,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [SLICE_WIDTH:0]   out_slice,
   output logic                   out_is_high,
   output logic                   out_last
);

   splitter_state_e        state_q, state_d;
   logic                   valid_q, valid_d;
   logic [SLICE_WIDTH:0]   slice_q, slice_d;
   logic [SLICE_WIDTH:0]   low_q, low_d;
   logic                   is_high_q, is_high_d;
   logic                   last_q, last_d;

   logic [SLICE_WIDTH:0]   high_slice;
   logic [SLICE_WIDTH:0]   low_slice;
   logic                   beat_acc;
   logic                   in_acc;

   pe_slice_extend #(
      .SLICE_WIDTH (SLICE_WIDTH),
      .DATA_WIDTH  (DATA_WIDTH)
   ) u_slice_extend (
      .operand_i (in_data),
      .wide_i    (in_wide),
      .high_o    (high_slice),
      .low_o     (low_slice)
   );

   assign beat_acc = valid_q && out_ready;
   assign in_ready = (state_q == IDLE) || (beat_acc && last_q);
   assign in_acc   = in_valid && in_ready;

   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      slice_d   = slice_q;
      low_d     = low_q;
      is_high_d = is_high_q;
      last_d    = last_q;

      case (state_q)
         HIGH: begin
            if (beat_acc) begin
               state_d   = LOW;
               slice_d   = low_q;
               is_high_d = 1'b0;
               last_d    = 1'b1;
            end
         end
         LOW, NARROW: begin
            if (beat_acc && !in_acc) begin
               state_d = IDLE;
               valid_d = 1'b0;
            end
         end
         default: ;
      endcase

      // A new operand may be taken from IDLE or while the last beat drains.
      if (in_acc) begin
         valid_d = 1'b1;
         if (in_wide) begin
            state_d   = HIGH;
            slice_d   = high_slice;
            low_d     = low_slice;
            is_high_d = 1'b1;
            last_d    = 1'b0;
         end else begin
            state_d   = NARROW;
            slice_d   = low_slice;
            is_high_d = 1'b0;
            last_d    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         valid_q   <= 1'b0;
         slice_q   <= '0;
         low_q     <= '0;
         is_high_q <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         slice_q   <= slice_d;
         low_q     <= low_d;
         is_high_q <= is_high_d;
         last_q    <= last_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_slice   = slice_q;
   assign out_is_high = is_high_q;
   assign out_last    = last_q;

endmodule : pe_operand_splitter
`default_nettype wire
